// File: rtl/ins_mem_arbiter_if.sv
// Requester-side handshake bundle for ins_mem_arbiter: one fetch channel and one
// load/store channel sharing the program/data BRAM.
`timescale 1ns/1ps
interface ins_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_gnt;
    logic [31:0] if_ins;
    logic        if_valid;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic [31:0] d_rdata;
    logic        d_valid;

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_ins, if_valid,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_gnt, d_rdata, d_valid
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_ins, if_valid,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_gnt, d_rdata, d_valid
    );
endinterface

// File: rtl/ins_mem_arbiter.sv
// Round-robin sequencer sharing a dual-port byte BRAM between instruction fetch and
// data load/store; each access is split into two-byte beats and reassembled little-endian.
`timescale 1ns/1ps
module ins_mem_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    ins_mem_arbiter_if.slave  bus,
    output logic              busy,
    output logic              ena,
    output logic              enb,
    output logic              wea,
    output logic              web,
    output logic [ADDR_W-1:0] addra,
    output logic [ADDR_W-1:0] addrb,
    output logic [7:0]        dina,
    output logic [7:0]        dinb,
    input  logic [7:0]        douta,
    input  logic [7:0]        doutb
);
    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, CAPT} state_e;

    state_e            state_q;
    logic              lastData_q, fetch_q, we_q, word_q, single_q, flushed_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0]       wdata_q, ins_q, rdata_q;
    logic [7:0]        b0_q, b1_q;
    logic              ifValid_q, dValid_q;
    logic              ena_q, enb_q, wea_q, web_q;
    logic [ADDR_W-1:0] addra_q, addrb_q;
    logic [7:0]        dina_q, dinb_q;

    logic              selData, selFetch, reqWe, reqWord, reqSingle;
    logic [ADDR_W-1:0] reqAddr;
    logic [31:0]       reqWdata, result;
    logic              unusedAddrBits;

    assign unusedAddrBits = ^{bus.if_addr[31:ADDR_W], bus.d_addr[31:ADDR_W]};

    // On a tie the requester that did not win the previous grant goes first.
    always_comb begin
        selData  = 1'b0;
        selFetch = 1'b0;
        if (state_q == IDLE) begin
            if (bus.d_req && bus.if_req) begin
                selData  = !lastData_q;
                selFetch = lastData_q;
            end else begin
                selData  = bus.d_req;
                selFetch = bus.if_req;
            end
        end
    end

    assign reqAddr   = selData ? bus.d_addr[ADDR_W-1:0] : bus.if_addr[ADDR_W-1:0];
    assign reqWe     = selData && bus.d_we;
    assign reqWord   = selData ? bus.d_size[1] : 1'b1;
    assign reqSingle = selData && (bus.d_size == 2'b00);
    assign reqWdata  = selData ? bus.d_wdata : '0;

    // The final read bytes arrive directly from the BRAM in CAPT and are merged unregistered.
    always_comb begin
        result = {doutb, douta, b1_q, b0_q};
        if (!word_q) begin
            result = single_q ? {24'b0, douta} : {16'b0, doutb, douta};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lastData_q <= 1'b0;
            fetch_q    <= 1'b0;
            we_q       <= 1'b0;
            word_q     <= 1'b0;
            single_q   <= 1'b0;
            flushed_q  <= 1'b0;
            base_q     <= '0;
            wdata_q    <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            ins_q      <= '0;
            rdata_q    <= '0;
            ifValid_q  <= 1'b0;
            dValid_q   <= 1'b0;
            ena_q      <= 1'b0;
            enb_q      <= 1'b0;
            wea_q      <= 1'b0;
            web_q      <= 1'b0;
            addra_q    <= '0;
            addrb_q    <= '0;
            dina_q     <= '0;
            dinb_q     <= '0;
        end else begin
            ifValid_q <= 1'b0;
            dValid_q  <= 1'b0;
            ena_q     <= 1'b0;
            enb_q     <= 1'b0;
            wea_q     <= 1'b0;
            web_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (selData || selFetch) begin
                        state_q    <= BEAT0;
                        lastData_q <= selData;
                        fetch_q    <= selFetch;
                        we_q       <= reqWe;
                        word_q     <= reqWord;
                        single_q   <= reqSingle;
                        flushed_q  <= selFetch && bus.if_flush;
                        base_q     <= reqAddr;
                        wdata_q    <= reqWdata;
                        ena_q      <= 1'b1;
                        enb_q      <= !reqSingle;
                        wea_q      <= reqWe;
                        web_q      <= reqWe && !reqSingle;
                        addra_q    <= reqAddr;
                        addrb_q    <= reqAddr + ADDR_W'(1);
                        dina_q     <= reqWdata[7:0];
                        dinb_q     <= reqWdata[15:8];
                    end
                end
                BEAT0: begin
                    if (word_q) begin
                        state_q <= BEAT1;
                        ena_q   <= 1'b1;
                        enb_q   <= 1'b1;
                        wea_q   <= we_q;
                        web_q   <= we_q;
                        addra_q <= base_q + ADDR_W'(2);
                        addrb_q <= base_q + ADDR_W'(3);
                        dina_q  <= wdata_q[23:16];
                        dinb_q  <= wdata_q[31:24];
                    end else if (we_q) begin
                        state_q  <= IDLE;
                        dValid_q <= 1'b1;
                    end else begin
                        state_q <= CAPT;
                    end
                end
                BEAT1: begin
                    b0_q <= douta;
                    b1_q <= doutb;
                    if (we_q) begin
                        state_q  <= IDLE;
                        dValid_q <= 1'b1;
                    end else begin
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    state_q <= IDLE;
                    if (fetch_q) begin
                        if (!(flushed_q || bus.if_flush)) begin
                            ins_q     <= result;
                            ifValid_q <= 1'b1;
                        end
                    end else begin
                        rdata_q  <= result;
                        dValid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A flush anywhere in the fetch's lifetime poisons its result.
            if (state_q != IDLE && fetch_q && bus.if_flush) begin
                flushed_q <= 1'b1;
            end
        end
    end

    assign bus.if_gnt   = selFetch;
    assign bus.d_gnt    = selData;
    assign bus.if_ins   = ins_q;
    assign bus.if_valid = ifValid_q;
    assign bus.d_rdata  = rdata_q;
    assign bus.d_valid  = dValid_q;
    assign busy         = (state_q != IDLE);
    assign ena          = ena_q;
    assign enb          = enb_q;
    assign wea          = wea_q;
    assign web          = web_q;
    assign addra        = addra_q;
    assign addrb        = addrb_q;
    assign dina         = dina_q;
    assign dinb         = dinb_q;
endmodule
